motion_delta_filter: RTL and testbench

Parametrised successor to the single-stream delta-frame stage in the object-tracking video path. It takes paired grayscale pixels (base frame and current frame) under a valid/ready handshake, forms the absolute difference and runs a true sliding-window moving average of any length. It then thresholds either the raw or the averaged magnitude into a binary motion mask for the downstream centroid/bounding logic. Optional hysteresis thresholding suppresses mask flicker at object edges.

---
 rtl/motion_delta_filter.sv | 148 ++++++++++++++
 tb/tb_motion_delta_filter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/motion_delta_filter.sv
// Absolute frame-difference, sliding-window moving average and thresholding into a binary motion mask.
// Optional hysteresis thresholding is enabled by defining MOTION_DELTA_HYST_EN.
module motion_delta_filter #(
  parameter int unsigned PIXEL_WIDTH   = 10,
  parameter int unsigned FILTER_LENGTH = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   is_filter,
  input  logic [PIXEL_WIDTH-1:0] threshold_hi,
  input  logic [PIXEL_WIDTH-1:0] threshold_lo,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] base_pixel,
  input  logic [PIXEL_WIDTH-1:0] curr_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_mag,
  output logic [PIXEL_WIDTH-1:0] out_mask
);

  localparam int unsigned SUM_W = PIXEL_WIDTH + $clog2(FILTER_LENGTH + 1);
  localparam int unsigned PTR_W = $clog2(FILTER_LENGTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FILTER_LENGTH - 1);
  localparam logic [SUM_W-1:0] DIVISOR  = SUM_W'(FILTER_LENGTH);

  logic                   en;
  logic                   upd;
  logic                   v1;
  logic [PIXEL_WIDTH-1:0] d1;
  logic [PIXEL_WIDTH-1:0] diff_c;
  logic [PIXEL_WIDTH-1:0] ring [FILTER_LENGTH];
  logic [SUM_W-1:0]       sum;
  logic [SUM_W-1:0]       sum_base;
  logic [SUM_W-1:0]       new_sum;
  logic [SUM_W-1:0]       quot;
  logic [PTR_W-1:0]       wptr;
  logic [PTR_W-1:0]       ptr_base;
  logic [PTR_W-1:0]       ptr_next;
  logic [PIXEL_WIDTH-1:0] old_entry;
  logic [PIXEL_WIDTH-1:0] avg;
  logic [PIXEL_WIDTH-1:0] comp;
  logic                   mask_bit;

  // Whole pipeline advances together; a stalled output freezes everything upstream.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign upd      = en & v1;

  always_comb begin
    diff_c = (curr_pixel >= base_pixel) ? (curr_pixel - base_pixel) : (base_pixel - curr_pixel);
  end

  // A coincident clear makes the update see an empty window.
  always_comb begin
    sum_base  = clear ? '0 : sum;
    ptr_base  = clear ? '0 : wptr;
    old_entry = clear ? '0 : ring[wptr];
    new_sum   = sum_base + SUM_W'(d1) - SUM_W'(old_entry);
    quot      = new_sum / DIVISOR;
    avg       = PIXEL_WIDTH'(quot);
    comp      = is_filter ? avg : d1;
    ptr_next  = (ptr_base == LAST_PTR) ? '0 : ptr_base + PTR_W'(1);
  end

`ifdef MOTION_DELTA_HYST_EN
  logic hyst;
  logic hyst_base;
  logic hyst_next;

  always_comb begin
    hyst_base = clear ? 1'b0 : hyst;
    hyst_next = hyst_base;
    if (comp > threshold_hi) begin
      hyst_next = 1'b1;
    end else if (comp < threshold_lo) begin
      hyst_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hyst <= 1'b0;
    end else if (upd) begin
      hyst <= hyst_next;
    end else if (clear) begin
      hyst <= 1'b0;
    end
  end

  assign mask_bit = hyst_next;
`else
  logic unused_threshold_lo;

  assign unused_threshold_lo = ^threshold_lo;
  assign mask_bit            = (comp > threshold_hi);
`endif

  // Stage 1: absolute difference.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else if (en) begin
      v1 <= in_valid;
      if (in_valid) begin
        d1 <= diff_c;
      end
    end
  end

  // Window history: ring, running sum and write pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ring <= '{default: '0};
      sum  <= '0;
      wptr <= '0;
    end else if (upd) begin
      if (clear) begin
        ring <= '{default: '0};
      end
      ring[ptr_base] <= d1;
      sum            <= new_sum;
      wptr           <= ptr_next;
    end else if (clear) begin
      ring <= '{default: '0};
      sum  <= '0;
      wptr <= '0;
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_mask  <= '0;
    end else if (en) begin
      out_valid <= v1;
      if (v1) begin
        out_mag  <= comp;
        out_mask <= {PIXEL_WIDTH{mask_bit}};
      end
    end
  end

endmodule

// File: tb/tb_motion_delta_filter.sv
// Scoreboard bench for motion_delta_filter with a 4-deep window; expected results are queued at
// acceptance and checked by an independent output monitor.
module tb_motion_delta_filter;

  localparam int unsigned PW = 10;
  localparam int unsigned FL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          is_filter;
  logic [PW-1:0] threshold_hi;
  logic [PW-1:0] threshold_lo;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] base_pixel;
  logic [PW-1:0] curr_pixel;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_mag;
  logic [PW-1:0] out_mask;

  typedef struct packed {
    logic [PW-1:0] mag;
    logic [PW-1:0] mask;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  motion_delta_filter #(.PIXEL_WIDTH(PW), .FILTER_LENGTH(FL)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .is_filter    (is_filter),
    .threshold_hi (threshold_hi),
    .threshold_lo (threshold_lo),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .base_pixel   (base_pixel),
    .curr_pixel   (curr_pixel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_mag      (out_mag),
    .out_mask     (out_mask)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Monitor: compares on accepted outputs, and checks hold behaviour while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        chk("output_without_expectation_qsize", q.size(), 1);
      end else if (out_ready) begin
        e = q.pop_front();
        chk("out_mag", int'(out_mag), int'(e.mag));
        chk("out_mask", int'(out_mask), int'(e.mask));
      end else begin
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_hold_mag", int'(out_mag), int'(q[0].mag));
        chk("stall_hold_mask", int'(out_mask), int'(q[0].mask));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int b, input int c, input bit push, input int emag, input bit emask);
    int   n;
    bit   acc;
    exp_t e;
    base_pixel = PW'(b);
    curr_pixel = PW'(c);
    in_valid   = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      chk("accept_timeout_cycles", n, 0);
    end else if (push) begin
      e.mag  = PW'(emag);
      e.mask = emask ? '1 : '0;
      q.push_back(e);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wr_d[6];
    int wr_m[6];
    int wr_k[6];
    int bp_d[8];
    int bp_m[8];
    int hy_d[4];
    int hy_k[4];

    wr_d = '{40, 40, 40, 40, 0, 0};
    wr_m = '{10, 20, 30, 40, 30, 20};
    wr_k = '{0, 0, 1, 1, 1, 0};
    bp_d = '{8, 16, 24, 32, 40, 4, 12, 100};
    bp_m = '{2, 6, 12, 20, 28, 25, 22, 39};
    hy_d = '{60, 30, 10, 30};
`ifdef MOTION_DELTA_HYST_EN
    hy_k = '{1, 1, 0, 0};
`else
    hy_k = '{1, 0, 0, 0};
`endif

    reset        = 1'b1;
    clear        = 1'b0;
    is_filter    = 1'b0;
    threshold_hi = PW'(50);
    threshold_lo = PW'(50);
    in_valid     = 1'b0;
    base_pixel   = '0;
    curr_pixel   = '0;
    out_ready    = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_mag", int'(out_mag), 0);
    chk("reset_out_mask", int'(out_mask), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Reset mid-stream: in-flight pixels must vanish.
    send(0, 7, 1'b0, 0, 1'b0);
    send(0, 9, 1'b0, 0, 1'b0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_out_mag", int'(out_mag), 0);
    chk("midreset_out_mask", int'(out_mask), 0);
    chk("midreset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    idle(3);

    // Raw mode, including the equal-to-threshold boundary and full scale.
    send(100, 30, 1'b1, 70, 1'b1);
    send(30, 60, 1'b1, 30, 1'b0);
    send(5, 5, 1'b1, 0, 1'b0);
    send(0, 50, 1'b1, 50, 1'b0);
    send(0, 51, 1'b1, 51, 1'b1);
    send(1023, 0, 1'b1, 1023, 1'b1);
    idle(4);

    // Averaged mode across a window wrap.
    pulse_clear();
    is_filter    = 1'b1;
    threshold_hi = PW'(25);
    threshold_lo = PW'(25);
    for (int i = 0; i < 6; i++) send(0, wr_d[i], 1'b1, wr_m[i], wr_k[i] != 0);
    idle(4);

    // Backpressure: three stalled cycles mid-stream.
    pulse_clear();
    threshold_hi = PW'(30);
    threshold_lo = PW'(30);
    fork
      begin
        for (int i = 0; i < 8; i++) send(0, bp_d[i], 1'b1, bp_m[i], i == 7);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(5);

    // Hysteresis versus single threshold.
    pulse_clear();
    is_filter    = 1'b0;
    threshold_hi = PW'(50);
    threshold_lo = PW'(20);
    for (int i = 0; i < 4; i++) send(0, hy_d[i], 1'b1, hy_d[i], hy_k[i] != 0);
    idle(4);

    // Clear coincident with a stage-2 update.
    pulse_clear();
    is_filter    = 1'b1;
    threshold_hi = PW'(1000);
    threshold_lo = PW'(1000);
    for (int i = 0; i < 4; i++) send(0, 80, 1'b1, 20 * (i + 1), 1'b0);
    idle(4);
    send(0, 80, 1'b1, 20, 1'b0);
    pulse_clear();
    send(0, 80, 1'b1, 40, 1'b0);
    idle(5);

    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
